// File: rtl/ycell_cfg_loader.sv
// Configuration loader for one ycell column: serializes 3-bit host words onto cbitin/confclk,
// captures the old chain contents from cbitret, and holds the column in reset until a full load.
module ycell_cfg_loader #(
   parameter int unsigned CELLS  = 16,
   parameter int unsigned PULSE  = 1,
   parameter int unsigned SETTLE = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [2:0] cfg_data,
   output logic       rb_valid,
   output logic [2:0] rb_data,
   output logic       busy,
   output logic       done,
   output logic       array_reset,
   output logic       confclk,
   output logic       cbitin,
   input  logic       cbitret
);

   localparam int unsigned WCW = $clog2(CELLS + 1);

   typedef enum logic [2:0] {StIdle, StWait, StSetup, StHigh, StSettle} state_t;

   state_t           state_q;
   logic [WCW-1:0]   word_cnt_q;
   logic [1:0]       bit_cnt_q;
   logic [3:0]       phase_q;
   logic [1:0]       shift_q;     // bits still to send after the one on cbitin
   logic [2:0]       rb_shift_q;

   assign cfg_ready = (state_q == StWait);
   assign busy      = (state_q != StIdle);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         word_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         phase_q     <= '0;
         shift_q     <= '0;
         rb_shift_q  <= '0;
         rb_data     <= '0;
         rb_valid    <= 1'b0;
         done        <= 1'b0;
         confclk     <= 1'b0;
         cbitin      <= 1'b0;
         array_reset <= 1'b1;
      end else begin
         rb_valid <= 1'b0;
         done     <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q     <= StWait;
                  array_reset <= 1'b1;
                  word_cnt_q  <= '0;
               end
            end
            StWait: begin
               if (cfg_valid) begin
                  cbitin    <= cfg_data[2];
                  shift_q   <= cfg_data[1:0];
                  bit_cnt_q <= '0;
                  phase_q   <= '0;
                  state_q   <= StSetup;
               end
            end
            StSetup: begin
               if (phase_q == 4'(PULSE - 1)) begin
                  // Sample before the chain shifts on the confclk rise below.
                  rb_shift_q <= {rb_shift_q[1:0], cbitret};
                  phase_q    <= '0;
                  confclk    <= 1'b1;
                  state_q    <= StHigh;
               end else begin
                  phase_q <= phase_q + 4'd1;
               end
            end
            StHigh: begin
               if (phase_q == 4'(PULSE - 1)) begin
                  confclk <= 1'b0;
                  phase_q <= '0;
                  if (bit_cnt_q != 2'd2) begin
                     bit_cnt_q <= bit_cnt_q + 2'd1;
                     cbitin    <= shift_q[1];
                     shift_q   <= {shift_q[0], 1'b0};
                     state_q   <= StSetup;
                  end else begin
                     word_cnt_q <= word_cnt_q + WCW'(1);
                     rb_valid   <= 1'b1;
                     rb_data    <= rb_shift_q;
                     if (word_cnt_q == WCW'(CELLS - 1)) begin
                        cbitin  <= 1'b0;
                        state_q <= StSettle;
                     end else begin
                        state_q <= StWait;
                     end
                  end
               end else begin
                  phase_q <= phase_q + 4'd1;
               end
            end
            StSettle: begin
               if (phase_q == 4'(SETTLE - 1)) begin
                  phase_q     <= '0;
                  array_reset <= 1'b0;
                  done        <= 1'b1;
                  state_q     <= StIdle;
               end else begin
                  phase_q <= phase_q + 4'd1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_ycell_cfg_loader.sv
// Directed bench for ycell_cfg_loader: three instances with different CELLS/PULSE/SETTLE,
// each driving a behavioural shift-register model of a ycell chain.
module tb_ycell_cfg_loader;

   localparam int NI = 3;
   localparam int unsigned CELLS_T  [NI] = '{1, 4, 1};
   localparam int unsigned PULSE_T  [NI] = '{1, 1, 3};
   localparam int unsigned SETTLE_T [NI] = '{2, 2, 4};

   logic          clk = 1'b0;
   logic          reset_n;
   logic [NI-1:0] start, cfg_valid, cfg_ready, rb_valid, busy, done;
   logic [NI-1:0] array_reset, confclk, cbitin, cbitret;
   logic [3*NI-1:0] cfg_data, rb_data;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int unsigned NB = 3 * CELLS_T[g];
      logic [NB-1:0] chain = '0;
      int            pulses = 0;

      ycell_cfg_loader #(
         .CELLS  (CELLS_T[g]),
         .PULSE  (PULSE_T[g]),
         .SETTLE (SETTLE_T[g])
      ) dut (
         .clk         (clk),
         .reset_n     (reset_n),
         .start       (start[g]),
         .cfg_valid   (cfg_valid[g]),
         .cfg_ready   (cfg_ready[g]),
         .cfg_data    (cfg_data[3*g +: 3]),
         .rb_valid    (rb_valid[g]),
         .rb_data     (rb_data[3*g +: 3]),
         .busy        (busy[g]),
         .done        (done[g]),
         .array_reset (array_reset[g]),
         .confclk     (confclk[g]),
         .cbitin      (cbitin[g]),
         .cbitret     (cbitret[g])
      );

      // Chain shifts toward the msb; the farthest cell's msb appears on cbitret.
      always @(posedge confclk[g]) begin
         if (NB > 1) chain <= {chain[NB-2:0], cbitin[g]};
         else        chain <= cbitin[g];
         pulses <= pulses + 1;
      end
      assign cbitret[g] = chain[NB-1];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse(input int i);
      start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
   endtask

   task automatic accept(input int i, input logic [2:0] w, output int at);
      int n = 0;
      cfg_valid[i] = 1'b1;
      cfg_data[3*i +: 3] = w;
      while (!cfg_ready[i] && n < 200) begin tick(); n++; end
      chk("accept_wait", 32'(cfg_ready[i]), 1);
      tick();
      at = cyc;
      cfg_valid[i] = 1'b0;
   endtask

   task automatic wait_rb(input int i, output logic [2:0] rb);
      int n = 0;
      while (!rb_valid[i] && n < 200) begin tick(); n++; end
      chk("rb_wait", 32'(rb_valid[i]), 1);
      rb = rb_data[3*i +: 3];
   endtask

   task automatic send_word(input int i, input logic [2:0] w, output logic [2:0] rb, output int at);
      accept(i, w, at);
      wait_rb(i, rb);
   endtask

   task automatic wait_done(input int i);
      int n = 0;
      while (!done[i] && n < 200) begin tick(); n++; end
      chk("done_wait", 32'(done[i]), 1);
      chk("done_array_reset", 32'(array_reset[i]), 0);
   endtask

   // Full 4-word load on instance 1 with optional host stall between words.
   task automatic load4(input logic [11:0] ws, input logic [11:0] exp_rb, input int stall);
      int at_prev = 0;
      int at = 0;
      int p0 = g_inst[1].pulses;
      logic [2:0] rb;
      start_pulse(1);
      for (int k = 0; k < 4; k++) begin
         send_word(1, ws[11-3*k -: 3], rb, at);
         chk("load_rb", 32'(rb), 32'(exp_rb[11-3*k -: 3]));
         if (k > 0) chk("load_spacing", 32'(at - at_prev), 32'(7 + stall));
         at_prev = at;
         if (k < 3) begin
            for (int s = 0; s < stall; s++) begin
               chk("stall_confclk", 32'(confclk[1]), 0);
               chk("stall_array_reset", 32'(array_reset[1]), 1);
               tick();
            end
         end
      end
      wait_done(1);
      chk("load_pulses", 32'(g_inst[1].pulses - p0), 12);
      tick();
      chk("done_one_cycle", 32'(done[1]), 0);
   endtask

   task automatic capture(input int i, input int n,
                          output logic [31:0] cc, output logic [31:0] cb, output logic [31:0] ar,
                          output logic [31:0] dn, output logic [31:0] rv);
      cc = '0; cb = '0; ar = '0; dn = '0; rv = '0;
      for (int k = 0; k < n; k++) begin
         cc = {cc[30:0], confclk[i]};
         cb = {cb[30:0], cbitin[i]};
         ar = {ar[30:0], array_reset[i]};
         dn = {dn[30:0], done[i]};
         rv = {rv[30:0], rb_valid[i]};
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] cc, cb, ar, dn, rv;
      logic [2:0]  rb;
      int          t;

      reset_n = 1'b0; start = '0; cfg_valid = '0; cfg_data = '0;
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_confclk", 32'(confclk), 0);
      chk("rst_cbitin", 32'(cbitin), 0);
      chk("rst_cfg_ready", 32'(cfg_ready), 0);
      chk("rst_rb_valid", 32'(rb_valid), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rb_data", 32'(rb_data), 0);
      chk("rst_array_reset", 32'(array_reset), 'b111);
      reset_n = 1'b1;
      tick(); tick();
      chk("idle_array_reset", 32'(array_reset), 'b111);
      chk("idle_cfg_ready", 32'(cfg_ready), 0);

      // Single word 101, CELLS=1, PULSE=1, SETTLE=2.
      start_pulse(0);
      chk("t1_ready", 32'(cfg_ready[0]), 1);
      chk("t1_busy", 32'(busy[0]), 1);
      accept(0, 3'b101, t);
      capture(0, 10, cc, cb, ar, dn, rv);
      chk("t1_confclk", cc, 'b0101010000);
      chk("t1_cbitin", cb, 'b1100110000);
      chk("t1_array_reset", ar, 'b1111111100);
      chk("t1_done", dn, 'b0000000010);
      chk("t1_rb_valid", rv, 'b0000001000);
      chk("t1_rb_data", 32'(rb_data[2:0]), 'b000);
      start_pulse(0);
      chk("t1_reload_array_reset", 32'(array_reset[0]), 1);
      send_word(0, 3'b011, rb, t);
      chk("t1_readback", 32'(rb), 'b101);
      wait_done(0);

      // Back-to-back, readback of identical load, then a stalled load.
      load4(12'b001_010_011_100, 12'b000_000_000_000, 0);
      load4(12'b001_010_011_100, 12'b001_010_011_100, 0);
      load4(12'b001_010_011_100, 12'b001_010_011_100, 5);

      // start while busy and cfg_valid during SETUP/HIGH are ignored.
      start_pulse(1);
      accept(1, 3'b110, t);
      cfg_valid[1] = 1'b1;
      cfg_data[5:3] = 3'b111;
      for (int s = 1; s <= 6; s++) begin
         chk("t4_ready_blocked", 32'(cfg_ready[1]), 0);
         start[1] = (s == 2);
         tick();
      end
      start[1] = 1'b0;
      chk("t4_rb_valid", 32'(rb_valid[1]), 1);
      chk("t4_rb0", 32'(rb_data[5:3]), 'b001);
      chk("t4_ready_again", 32'(cfg_ready[1]), 1);
      tick();
      cfg_valid[1] = 1'b0;
      wait_rb(1, rb);
      chk("t4_rb1", 32'(rb), 'b010);
      send_word(1, 3'b000, rb, t);
      chk("t4_rb2", 32'(rb), 'b011);
      send_word(1, 3'b101, rb, t);
      chk("t4_rb3", 32'(rb), 'b100);
      wait_done(1);
      load4(12'b001_010_011_100, 12'b110_111_000_101, 0);

      // Reset during HIGH of the second word leaves a 4-bit partial shift.
      start_pulse(1);
      send_word(1, 3'b111, rb, t);
      chk("t5_rb0", 32'(rb), 'b001);
      accept(1, 3'b100, t);
      chk("t5_setup_cbitin", 32'(cbitin[1]), 1);
      tick();
      chk("t5_high_confclk", 32'(confclk[1]), 1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_confclk", 32'(confclk[1]), 0);
      chk("t5_rst_cbitin", 32'(cbitin[1]), 0);
      chk("t5_rst_busy", 32'(busy[1]), 0);
      chk("t5_rst_array_reset", 32'(array_reset[1]), 1);
      tick();
      reset_n = 1'b1;
      tick(); tick();
      chk("t5_post_array_reset", 32'(array_reset[1]), 1);
      chk("t5_post_done", 32'(done[1]), 0);
      load4(12'b001_010_011_100, 12'b100_111_001_111, 0);

      // PULSE=3, SETTLE=4.
      start_pulse(2);
      accept(2, 3'b110, t);
      capture(2, 24, cc, cb, ar, dn, rv);
      chk("t6_confclk", cc, 'b000111000111000111000000);
      chk("t6_cbitin", cb, 'b111111111111000000000000);
      chk("t6_array_reset", ar, 'b111111111111111111111100);
      chk("t6_done", dn, 'b000000000000000000000010);
      chk("t6_rb_valid", rv, 'b000000000000000000100000);
      chk("t6_rb_data", 32'(rb_data[8:6]), 'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
